// File: rtl/decl_stream_pkg.sv
// Shared types and constants for the declaration-stream checker and its lexer helpers.
package decl_stream_pkg;

  typedef enum logic [2:0] {
    StIdle, StKw, StPreId, StId, StPostId, StDone, StErr
  } state_e;

  typedef enum logic [2:0] {
    CcWs, CcAlpha, CcDigit, CcComma, CcSemi, CcOther
  } char_class_e;

  localparam logic [7:0] ASCII_SPACE      = 8'h20;
  localparam logic [7:0] ASCII_TAB        = 8'h09;
  localparam logic [7:0] ASCII_COMMA      = 8'h2c;
  localparam logic [7:0] ASCII_SEMI       = 8'h3b;
  localparam logic [7:0] ASCII_UNDERSCORE = 8'h5f;
  localparam logic [7:0] ASCII_I          = 8'h69;
  localparam logic [7:0] ASCII_N          = 8'h6e;
  localparam logic [7:0] ASCII_T          = 8'h74;
  localparam logic [7:0] ASCII_C          = 8'h63;
  localparam logic [7:0] ASCII_H          = 8'h68;
  localparam logic [7:0] ASCII_A          = 8'h61;
  localparam logic [7:0] ASCII_R          = 8'h72;

  localparam logic [2:0] KW_INT_LEN  = 3'd3;
  localparam logic [2:0] KW_CHAR_LEN = 3'd4;

  function automatic logic [7:0] int_char(input logic [7:0] idx);
    case (idx)
      8'd0:    return ASCII_I;
      8'd1:    return ASCII_N;
      8'd2:    return ASCII_T;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] char_char(input logic [7:0] idx);
    case (idx)
      8'd0:    return ASCII_C;
      8'd1:    return ASCII_H;
      8'd2:    return ASCII_A;
      8'd3:    return ASCII_R;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/decl_char_class.sv
// Combinational ASCII character classifier shared by the lexer blocks.
module decl_char_class
  import decl_stream_pkg::*;
(
  input  logic [7:0]  ch,
  output char_class_e cls
);

  always_comb begin
    cls = CcOther;
    if (ch == ASCII_SPACE || ch == ASCII_TAB) begin
      cls = CcWs;
    end else if ((ch >= 8'h61 && ch <= 8'h7a) || (ch >= 8'h41 && ch <= 8'h5a) ||
                 ch == ASCII_UNDERSCORE) begin
      cls = CcAlpha;
    end else if (ch >= 8'h30 && ch <= 8'h39) begin
      cls = CcDigit;
    end else if (ch == ASCII_COMMA) begin
      cls = CcComma;
    end else if (ch == ASCII_SEMI) begin
      cls = CcSemi;
    end
  end

endmodule

// File: rtl/decl_stream_check.sv
// Streaming checker for C-style "int a, b;" declarations with identifier counting.
// Optional macro DECL_CHAR_TYPE_EN adds "char" as a type keyword and reserved word.
module decl_stream_check
  import decl_stream_pkg::*;
#(
  parameter int unsigned MAX_ID_LEN = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in,
  output logic             out,
  output logic [CNT_W-1:0] id_count,
  output logic             err
);

  char_class_e      cls;
  state_e           state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] id_count_q, id_count_d;
  logic [2:0]       kw_idx_q, kw_idx_d;
  logic             int_m_q, int_m_d;
  logic             err_q, err_d;
  logic             out_q;
  logic [2:0]       kw_len;
  logic [7:0]       kw_exp;
  logic             id_reserved;
`ifdef DECL_CHAR_TYPE_EN
  logic             kw_char_q, kw_char_d;
  logic             char_m_q, char_m_d;
`endif

  decl_char_class u_class (
    .ch  (in),
    .cls (cls)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

`ifdef DECL_CHAR_TYPE_EN
  assign kw_len      = kw_char_q ? KW_CHAR_LEN : KW_INT_LEN;
  assign kw_exp      = kw_char_q ? char_char(8'(kw_idx_q)) : int_char(8'(kw_idx_q));
  assign id_reserved = (int_m_q && len_q == 8'(KW_INT_LEN)) ||
                       (char_m_q && len_q == 8'(KW_CHAR_LEN));
`else
  assign kw_len      = KW_INT_LEN;
  assign kw_exp      = int_char(8'(kw_idx_q));
  assign id_reserved = int_m_q && len_q == 8'(KW_INT_LEN);
`endif

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    id_count_d = id_count_q;
    kw_idx_d   = kw_idx_q;
    int_m_d    = int_m_q;
    err_d      = 1'b0;
`ifdef DECL_CHAR_TYPE_EN
    kw_char_d  = kw_char_q;
    char_m_d   = char_m_q;
`endif
    if (in_valid) begin
      unique case (state_q)
        StIdle, StDone: begin
          if (cls == CcWs || cls == CcSemi) begin
            state_d = StIdle;
          end else if (in == ASCII_I) begin
            state_d  = StKw;
            kw_idx_d = 3'd1;
`ifdef DECL_CHAR_TYPE_EN
            kw_char_d = 1'b0;
          end else if (in == ASCII_C) begin
            state_d   = StKw;
            kw_idx_d  = 3'd1;
            kw_char_d = 1'b1;
`endif
          end else begin
            state_d = StErr;
            err_d   = 1'b1;
          end
        end
        StKw: begin
          if (kw_idx_q == kw_len) begin
            if (cls == CcWs) begin
              state_d = StPreId;
              cnt_d   = '0;
            end else begin
              state_d = (cls == CcSemi) ? StIdle : StErr;
              err_d   = 1'b1;
            end
          end else if (in == kw_exp) begin
            kw_idx_d = kw_idx_q + 3'd1;
          end else begin
            state_d = (cls == CcSemi) ? StIdle : StErr;
            err_d   = 1'b1;
          end
        end
        StPreId: begin
          if (cls == CcAlpha) begin
            state_d = StId;
            len_d   = 8'd1;
            int_m_d = (in == int_char(8'd0));
`ifdef DECL_CHAR_TYPE_EN
            char_m_d = (in == char_char(8'd0));
`endif
          end else if (cls != CcWs) begin
            state_d = (cls == CcSemi) ? StIdle : StErr;
            err_d   = 1'b1;
          end
        end
        StId: begin
          if (cls == CcAlpha || cls == CcDigit) begin
            if (len_q == 8'(MAX_ID_LEN)) begin
              state_d = StErr;
              err_d   = 1'b1;
            end else begin
              len_d   = len_q + 8'd1;
              // Prefix flags die once the identifier outgrows or diverges from the keyword.
              int_m_d = int_m_q && (len_q < 8'(KW_INT_LEN)) && (in == int_char(len_q));
`ifdef DECL_CHAR_TYPE_EN
              char_m_d = char_m_q && (len_q < 8'(KW_CHAR_LEN)) && (in == char_char(len_q));
`endif
            end
          end else if (cls == CcOther) begin
            state_d = StErr;
            err_d   = 1'b1;
          end else if (id_reserved) begin
            state_d = (cls == CcSemi) ? StIdle : StErr;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_inc;
            unique case (cls)
              CcWs:    state_d = StPostId;
              CcComma: state_d = StPreId;
              default: begin
                state_d    = StDone;
                id_count_d = cnt_inc;
              end
            endcase
          end
        end
        StPostId: begin
          if (cls == CcComma) begin
            state_d = StPreId;
          end else if (cls == CcSemi) begin
            state_d    = StDone;
            id_count_d = cnt_q;
          end else if (cls != CcWs) begin
            state_d = StErr;
            err_d   = 1'b1;
          end
        end
        StErr: begin
          if (cls == CcSemi) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      len_q      <= '0;
      cnt_q      <= '0;
      id_count_q <= '0;
      kw_idx_q   <= '0;
      int_m_q    <= 1'b0;
      err_q      <= 1'b0;
      out_q      <= 1'b0;
`ifdef DECL_CHAR_TYPE_EN
      kw_char_q  <= 1'b0;
      char_m_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      id_count_q <= id_count_d;
      kw_idx_q   <= kw_idx_d;
      int_m_q    <= int_m_d;
      err_q      <= err_d;
      out_q      <= (state_d == StDone);
`ifdef DECL_CHAR_TYPE_EN
      kw_char_q  <= kw_char_d;
      char_m_q   <= char_m_d;
`endif
    end
  end

  assign out      = out_q;
  assign id_count = id_count_q;
  assign err      = err_q;

endmodule

// File: tb/tb_decl_stream_check.sv
// Scoreboard bench for decl_stream_check: per-statement expected out/id_count/err results.
module tb_decl_stream_check;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in;
  logic       out;
  logic [3:0] id_count;
  logic       err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       out;
    logic [3:0] idc;
    int         errs;
    int         err_idx;
  } res_t;

  res_t  exp_q[$];
  res_t  obs_q[$];
  string name_q[$];

  decl_stream_check #(
    .MAX_ID_LEN (8),
    .CNT_W      (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in       (in),
    .out      (out),
    .id_count (id_count),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic expect_res(input string nm, input logic o, input logic [3:0] c,
                            input int errs, input int idx);
    res_t r;
    r.out = o; r.idc = c; r.errs = errs; r.err_idx = idx;
    exp_q.push_back(r);
    name_q.push_back(nm);
  endtask

  // Drives one statement; optional idle gaps carry garbage bytes on `in`.
  task automatic send_str(input string s, input bit gaps);
    res_t r;
    r.errs = 0;
    r.err_idx = -1;
    for (int i = 0; i < s.len(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(1, 2)) begin
          in_valid = 1'b0;
          in = 8'($urandom_range(0, 255));
          @(posedge clk); #1;
          if (err) r.errs++;
        end
      end
      in_valid = 1'b1;
      in = s[i];
      @(posedge clk); #1;
      if (err) begin
        if (r.err_idx < 0) r.err_idx = i;
        r.errs++;
      end
    end
    in_valid = 1'b0;
    in = 8'h00;
    r.out = out;
    r.idc = id_count;
    obs_q.push_back(r);
  endtask

  task automatic drain(input string tag);
    res_t e, o;
    string nm;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      nm = name_q.pop_front();
      total++;
      if (o.out !== e.out) begin
        bad++;
        $display("FAIL %s/%s out: got %0b want %0b", tag, nm, o.out, e.out);
      end
      total++;
      if (o.idc !== e.idc) begin
        bad++;
        $display("FAIL %s/%s id_count: got %0d want %0d", tag, nm, o.idc, e.idc);
      end
      total++;
      if (o.errs !== e.errs) begin
        bad++;
        $display("FAIL %s/%s err pulses: got %0d want %0d", tag, nm, o.errs, e.errs);
      end
      total++;
      if (o.err_idx !== e.err_idx) begin
        bad++;
        $display("FAIL %s/%s err position: got %0d want %0d", tag, nm, o.err_idx, e.err_idx);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    in = "i";
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (out !== 1'b0) begin bad++; $display("FAIL reset out: got %0b want 0", out); end
    total++;
    if (id_count !== 4'd0) begin bad++; $display("FAIL reset id_count: got %0d want 0", id_count); end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL reset err: got %0b want 0", err); end
    reset = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_basic();
    expect_res("two_ids", 1'b1, 4'd2, 0, -1);
    send_str("int a, b_1 ;", 1'b0);
    drain("basic");
    // out must hold and err stay low while the stream is idle.
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL basic_hold out/err: got %0b/%0b want 1/0", out, err);
    end
  endtask

  task automatic test_keyword_errors();
    expect_res("int_int", 1'b0, 4'd2, 1, 7);
    send_str("int int;", 1'b0);
    expect_res("int_semi", 1'b0, 4'd2, 1, 3);
    send_str("int;", 1'b0);
    expect_res("intx", 1'b0, 4'd2, 1, 3);
    send_str("intx;", 1'b0);
    expect_res("in_t", 1'b0, 4'd2, 1, 2);
    send_str("in t;", 1'b0);
    expect_res("other_lead", 1'b0, 4'd2, 1, 0);
    send_str("x;", 1'b0);
    expect_res("missing_id", 1'b0, 4'd2, 1, 6);
    send_str("int a,;", 1'b0);
    drain("keyword");
  endtask

  task automatic test_max_len();
    expect_res("len8", 1'b1, 4'd1, 0, -1);
    send_str("int abcdefgh;", 1'b0);
    expect_res("len9", 1'b0, 4'd1, 1, 12);
    send_str("int abcdefghi;", 1'b0);
    drain("max_len");
  endtask

  task automatic test_recovery();
    expect_res("a_b_then_c", 1'b1, 4'd1, 1, 6);
    send_str("int a b; int c;", 1'b0);
    drain("recovery");
  endtask

  task automatic test_names_and_empty();
    expect_res("legal_names", 1'b1, 4'd3, 0, -1);
    send_str("int in, int2 ,integer\t;", 1'b0);
    expect_res("post_id", 1'b1, 4'd2, 0, -1);
    send_str("  int a ,b ;", 1'b0);
    expect_res("bare_semi", 1'b0, 4'd2, 0, -1);
    send_str(";", 1'b0);
    expect_res("ws_semi", 1'b0, 4'd2, 0, -1);
    send_str(" \t;", 1'b0);
    drain("names");
  endtask

  task automatic test_saturation();
    expect_res("seventeen", 1'b1, 4'd15, 0, -1);
    send_str("int a,b,c,d,e,f,g,h,i,j,k,l,m,n,o,p,q;", 1'b0);
    drain("saturation");
  endtask

  task automatic test_valid_gaps();
    expect_res("gapped", 1'b1, 4'd1, 0, -1);
    send_str("int a;", 1'b1);
    drain("valid_gaps");
  endtask

  task automatic test_char_type();
`ifdef DECL_CHAR_TYPE_EN
    expect_res("char_reserved", 1'b0, 4'd1, 1, 11);
    send_str("char x,char;", 1'b0);
    expect_res("char_decl", 1'b1, 4'd1, 0, -1);
    send_str("char x;", 1'b0);
`else
    expect_res("char_unknown", 1'b0, 4'd1, 1, 0);
    send_str("char x;", 1'b0);
    expect_res("char_as_id", 1'b1, 4'd1, 0, -1);
    send_str("int char;", 1'b0);
`endif
    drain("char_type");
  endtask

  task automatic test_reset_mid();
    expect_res("partial", 1'b0, 4'd1, 0, -1);
    send_str("int a", 1'b0);
    drain("reset_mid");
    reset = 1'b1;
    in_valid = 1'b1;
    in = ";";
    @(posedge clk); #1;
    total++;
    if (out !== 1'b0 || id_count !== 4'd0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid out/id_count/err: got %0b/%0d/%0b want 0/0/0", out, id_count, err);
    end
    reset = 1'b0;
    in_valid = 1'b0;
    expect_res("after_reset", 1'b1, 4'd1, 0, -1);
    send_str("int a;", 1'b0);
    drain("reset_mid");
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in = 8'h00;
    test_reset();
    test_basic();
    test_keyword_errors();
    test_max_len();
    test_recovery();
    test_names_and_empty();
    test_saturation();
    test_valid_gaps();
    test_char_type();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
